matvec_engine: RTL and testbench
================================

# matvec_engine

Sequencing matrix-vector multiply stage of the RNN datapath, directly downstream of the parameter loaders. Once the 2-D weight loader (4 rows × 16 columns) and the 1-D input loader (16 entries) are populated, `matvec_engine` sweeps their read selects. It multiply-accumulates signed Q8.8 operands and emits one saturated Q8.8 dot product per row. Results feed the activation stage.

## Interface
- `ROWS`, default 4: matrix rows; drives `mat_seli` width (clog2).
- `COLS`, default 16: matrix columns / vector length; drives `mat_selj`/`vec_sel` width (clog2).
- `DW`, default 16: operand and result width, signed two's complement.
- `FRAC`, default 8: fractional bits (Q8.8).
- `ACCW`, default 36: accumulator width (2·DW + clog2(COLS)).

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `busy` out 1: high from the cycle after accepted `start` through the `done` cycle.
- `done` out 1: one-cycle pulse, coincident with the last row's `result_valid`.
- `mat_seli` out 2: row select to 2-D loader.
- `mat_selj` out 4: column select to 2-D loader.
- `vec_sel` out 4: select to 1-D loader; always equals `mat_selj`.
- `mat_data` in 16: 2-D loader `param_out`, combinational on selects.
- `vec_data` in 16: 1-D loader `param_out`, combinational on select.
- `result_valid` out 1: one-cycle pulse per completed row.
- `result_row` out 2: row index of `result`.
- `result` out 16: saturated Q8.8 dot product.

## Operation
- Reset values: `busy`, `done`, `result_valid` = 0; `mat_seli`, `mat_selj`, `vec_sel`, `result_row`, `result` = 0; accumulator and product register = 0; state = IDLE.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN on `start`.
  - RUN → DRAIN after issuing address (ROWS−1, COLS−1).
  - DRAIN → DONE after 1 cycle.
  - DONE → IDLE after 1 cycle.
- RUN addressing:
  - Starts at (0,0). `mat_selj` increments every cycle.
  - At COLS−1, `mat_selj` wraps to 0 and `mat_seli` increments.
  - In IDLE, DRAIN and DONE the selects hold 0.
- Pipeline stage 1: `prod <= $signed(mat_data) * $signed(vec_data)`, 32-bit Q16.16. Captured only for addresses issued in RUN; otherwise `prod <= 0`.
- Pipeline stage 2: `acc <= acc + sext(prod)`.
  - On the product for column COLS−1, `result <= sat(final_sum >>> FRAC)` and `acc <= 0` on the same edge. Here `final_sum` = `acc + prod`.
  - `result_valid` = 1 and `result_row` = that row, both registered.
- Shift is arithmetic (floor toward −∞). Saturation clamps to [0x8000, 0x7FFF].
- `start` while `busy`: ignored, no effect on the sequence.
- `reset` mid-operation: immediate return to IDLE with all outputs at reset values. No partial `result_valid` or `done`. A fresh `start` afterwards runs a full 66-cycle pass.

## Timing
- Cycle 0 is the edge sampling `start`.
- Address (r,j) is driven in cycle 1+16r+j.
- Product for (r,j) is visible in cycle 2+16r+j and accumulated at the end of that cycle.
- Row r `result_valid` is high in cycle 18+16r, i.e. cycles 18, 34, 50, 66.
- `busy` is high in cycles 1–66.
- `done` is high in cycle 66 only.
- A new `start` can be accepted in cycle 67.
- Throughput: one MAC per cycle; 66 cycles per pass.

## Test plan
Bench models both loaders as combinational arrays.
- **Unity operands.** All matrix = 0x0100, all vector = 0x0100, pulse `start` → `result` = 0x1000 for rows 0–3 at cycles 18/34/50/66; `done` at 66; `busy` low at 67.
- **Per-row scaling.** Row r = (r+1)·0x0100, vector = 0x0080 → results 0x0800, 0x1000, 0x1800, 0x2000 with `result_row` 0–3.
- **Negative products.** Matrix = 0xFF00, vector = 0x0200 → every `result` = 0xE000 (−32.0).
  - Mixed signs so that Σ = 0x7FFF·0x7FFF·16 → `result` = 0x7FFF. Matrix = 0x8000 with vector = 0x7FFF → 0x8000.
- **Truncation.** Matrix = 0x0001, vector = 0xFFFF → acc = −16, `result` = 0xFFFF (floor). Matrix = 0x0001, vector = 0x0001 → 0x0000.
- **Busy and reset.** `start` re-pulsed at cycle 10 → no effect, same timing. `reset` asserted at cycle 30 → `busy`, `result_valid`, `done` and selects go 0 with no further pulses. New `start` → correct unity results at cycles 18–66 relative to it.

Source files
------------

// File: rtl/matvec_engine.sv
// Matrix-vector multiply sequencer: sweeps the 2-D weight and 1-D input loader
// selects, multiply-accumulates signed fixed-point operands and emits one
// saturated dot product per matrix row.
//
// state   | meaning
// IDLE    | waiting for start, selects parked at 0
// RUN     | issuing one (row, col) address per cycle
// DRAIN   | last product in flight through the accumulator
// DONE    | last row result and done pulse presented
module matvec_engine #(
  parameter int ROWS = 4,
  parameter int COLS = 16,
  parameter int DW   = 16,
  parameter int FRAC = 8,
  parameter int ACCW = 36
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [$clog2(ROWS)-1:0] mat_seli,
  output logic [$clog2(COLS)-1:0] mat_selj,
  output logic [$clog2(COLS)-1:0] vec_sel,
  input  logic [DW-1:0]           mat_data,
  input  logic [DW-1:0]           vec_data,
  output logic                    result_valid,
  output logic [$clog2(ROWS)-1:0] result_row,
  output logic [DW-1:0]           result
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int PW = 2 * DW;
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
  localparam logic [DW-1:0] SAT_POS  = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] SAT_NEG  = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t r_state;
  logic              r_busy;
  logic              r_done;
  logic [RW-1:0]     r_seli;
  logic [CW-1:0]     r_selj;

  logic signed [PW-1:0]   r_prod;
  logic                   r_pv;
  logic [RW-1:0]          r_prow;
  logic [CW-1:0]          r_pcol;
  logic signed [ACCW-1:0] r_acc;
  logic                   r_rv;
  logic [RW-1:0]          r_rrow;
  logic [DW-1:0]          r_result;

  logic signed [PW-1:0]   w_mat_x;
  logic signed [PW-1:0]   w_vec_x;
  logic signed [PW-1:0]   w_prod;
  logic signed [ACCW-1:0] w_prod_x;
  logic signed [ACCW-1:0] w_sum;
  logic signed [ACCW-1:0] w_shift;
  logic                   w_fits;
  logic [DW-1:0]          w_sat;

  assign w_mat_x  = PW'($signed(mat_data));
  assign w_vec_x  = PW'($signed(vec_data));
  assign w_prod   = w_mat_x * w_vec_x;
  assign w_prod_x = ACCW'(r_prod);
  assign w_sum    = r_acc + w_prod_x;
  assign w_shift  = w_sum >>> FRAC;
  // The shifted sum fits the result when every bit above the result sign bit
  // matches that sign bit.
  assign w_fits   = (w_shift[ACCW-1:DW-1] == '0) || (w_shift[ACCW-1:DW-1] == '1);
  assign w_sat    = w_fits ? w_shift[DW-1:0] : (w_shift[ACCW-1] ? SAT_NEG : SAT_POS);

  assign busy         = r_busy;
  assign done         = r_done;
  assign mat_seli     = r_seli;
  assign mat_selj     = r_selj;
  assign vec_sel      = r_selj;
  assign result_valid = r_rv;
  assign result_row   = r_rrow;
  assign result       = r_result;

  // Sequencer: state, busy/done flags and the loader address sweep.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_seli  <= '0;
      r_selj  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
          end
        end
        S_RUN: begin
          if (r_selj == LAST_COL) begin
            r_selj <= '0;
            if (r_seli == LAST_ROW) begin
              r_seli  <= '0;
              r_state <= S_DRAIN;
            end else begin
              r_seli <= r_seli + RW'(1);
            end
          end else begin
            r_selj <= r_selj + CW'(1);
          end
        end
        S_DRAIN: begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Two-stage MAC: register the product (zero outside RUN), then accumulate
  // and close out a row when its last column's product arrives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prod   <= '0;
      r_pv     <= 1'b0;
      r_prow   <= '0;
      r_pcol   <= '0;
      r_acc    <= '0;
      r_rv     <= 1'b0;
      r_rrow   <= '0;
      r_result <= '0;
    end else begin
      r_pv   <= (r_state == S_RUN);
      r_prow <= r_seli;
      r_pcol <= r_selj;
      r_prod <= (r_state == S_RUN) ? w_prod : '0;
      if (r_pv && (r_pcol == LAST_COL)) begin
        r_result <= w_sat;
        r_rrow   <= r_prow;
        r_rv     <= 1'b1;
        r_acc    <= '0;
      end else begin
        r_rv  <= 1'b0;
        r_acc <= w_sum;
      end
    end
  end

endmodule

// File: tb/tb_matvec_engine.sv
// Self-checking bench for matvec_engine: loaders modelled as arrays, directed
// vector table, busy/reset sequences and randomized passes against an
// arithmetic reference model.
module tb_matvec_engine;

  logic        clk;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic [1:0]  mat_seli;
  logic [3:0]  mat_selj;
  logic [3:0]  vec_sel;
  logic [15:0] mat_data;
  logic [15:0] vec_data;
  logic        result_valid;
  logic [1:0]  result_row;
  logic [15:0] result;

  logic [15:0] mat [4][16];
  logic [15:0] vec [16];
  logic [15:0] exp_res [4];

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0][15:0] mrow;
    logic [15:0]      vval;
    logic [3:0][15:0] exp;
  } vec_t;

  vec_t tv [9];

  matvec_engine dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .mat_seli(mat_seli), .mat_selj(mat_selj), .vec_sel(vec_sel),
    .mat_data(mat_data), .vec_data(vec_data),
    .result_valid(result_valid), .result_row(result_row), .result(result)
  );

  assign mat_data = mat[mat_seli][mat_selj];
  assign vec_data = vec[vec_sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, k, act, expv);
    end
  endtask

  // Reference: exact integer dot product, floor shift, clamp.
  function automatic logic [15:0] ref_row(input int r);
    longint s;
    s = 0;
    for (int j = 0; j < 16; j++)
      s += longint'($signed(mat[r][j])) * longint'($signed(vec[j]));
    s = s >>> 8;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return 16'(s);
  endfunction

  task automatic load_uniform(input vec_t v);
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 16; j++)
        mat[r][j] = v.mrow[r];
    for (int j = 0; j < 16; j++) vec[j] = v.vval;
  endtask

  // One full pass; expectations derived from the cycle-numbered timing.
  task automatic run_pass(input int restart_cyc, input int reset_cyc,
                          input bit pre_started, input bit chain_next);
    bit in_rst, bz, dn, rv;
    logic [1:0] ei;
    logic [3:0] ej;
    if (!pre_started) begin
      @(negedge clk);
      start = 1'b1;
    end
    @(posedge clk);
    for (int k = 1; k <= 67; k++) begin
      @(negedge clk);
      start = (k == restart_cyc);
      if (reset_cyc > 0 && k == reset_cyc) reset = 1'b1;
      else if (reset_cyc > 0 && k == reset_cyc + 1) reset = 1'b0;
      #1;
      in_rst = (reset_cyc > 0) && (k >= reset_cyc);
      bz = !in_rst && (k <= 66);
      dn = !in_rst && (k == 66);
      rv = !in_rst && (k >= 18) && (k <= 66) && (((k - 18) % 16) == 0);
      if (!in_rst && k <= 64) begin
        ei = 2'((k - 1) / 16);
        ej = 4'((k - 1) % 16);
      end else begin
        ei = '0;
        ej = '0;
      end
      chk("busy", k, 32'(busy), 32'(bz));
      chk("done", k, 32'(done), 32'(dn));
      chk("result_valid", k, 32'(result_valid), 32'(rv));
      chk("mat_seli", k, 32'(mat_seli), 32'(ei));
      chk("mat_selj", k, 32'(mat_selj), 32'(ej));
      chk("vec_sel", k, 32'(vec_sel), 32'(ej));
      if (rv) begin
        chk("result_row", k, 32'(result_row), 32'((k - 18) / 16));
        chk("result", k, 32'(result), 32'(exp_res[(k - 18) / 16]));
      end
      if (reset_cyc > 0 && k == reset_cyc) begin
        chk("result_after_reset", k, 32'(result), 32'h0);
        chk("result_row_after_reset", k, 32'(result_row), 32'h0);
      end
    end
    if (chain_next) start = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 16; j++) mat[r][j] = '0;
    for (int j = 0; j < 16; j++) vec[j] = '0;

    tv[0] = '{mrow: {4{16'h0100}}, vval: 16'h0100, exp: {4{16'h1000}}};
    tv[1] = '{mrow: {16'h0400, 16'h0300, 16'h0200, 16'h0100}, vval: 16'h0080,
              exp: {16'h2000, 16'h1800, 16'h1000, 16'h0800}};
    tv[2] = '{mrow: {4{16'hFF00}}, vval: 16'h0200, exp: {4{16'hE000}}};
    tv[3] = '{mrow: {4{16'h7FFF}}, vval: 16'h7FFF, exp: {4{16'h7FFF}}};
    tv[4] = '{mrow: {4{16'h8001}}, vval: 16'h8001, exp: {4{16'h7FFF}}};
    tv[5] = '{mrow: {4{16'h8000}}, vval: 16'h7FFF, exp: {4{16'h8000}}};
    tv[6] = '{mrow: {4{16'h0001}}, vval: 16'hFFFF, exp: {4{16'hFFFF}}};
    tv[7] = '{mrow: {4{16'h0001}}, vval: 16'h0001, exp: {4{16'h0000}}};
    tv[8] = '{mrow: {4{16'h8000}}, vval: 16'h8000, exp: {4{16'h7FFF}}};

    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", 0, 32'(busy), 32'h0);
    chk("rst_done", 0, 32'(done), 32'h0);
    chk("rst_result_valid", 0, 32'(result_valid), 32'h0);
    chk("rst_mat_seli", 0, 32'(mat_seli), 32'h0);
    chk("rst_mat_selj", 0, 32'(mat_selj), 32'h0);
    chk("rst_vec_sel", 0, 32'(vec_sel), 32'h0);
    chk("rst_result_row", 0, 32'(result_row), 32'h0);
    chk("rst_result", 0, 32'(result), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("idle_busy", 0, 32'(busy), 32'h0);

    // Directed table; first pass chains a start in cycle 67 into the second.
    for (int i = 0; i < 9; i++) begin
      load_uniform(tv[i]);
      for (int r = 0; r < 4; r++) exp_res[r] = tv[i].exp[r];
      run_pass(0, 0, (i == 1), (i == 0));
    end

    // start re-pulsed while busy: timing and results unchanged.
    load_uniform(tv[0]);
    for (int r = 0; r < 4; r++) exp_res[r] = 16'h1000;
    run_pass(10, 0, 1'b0, 1'b0);

    // reset mid-pass, then a fresh full unity pass.
    run_pass(0, 30, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    run_pass(0, 0, 1'b0, 1'b0);

    // Randomized passes against the reference model.
    for (int p = 0; p < 6; p++) begin
      for (int r = 0; r < 4; r++)
        for (int j = 0; j < 16; j++)
          mat[r][j] = (p < 3) ? 16'($urandom) : 16'($signed(10'($urandom)));
      for (int j = 0; j < 16; j++)
        vec[j] = (p < 3) ? 16'($urandom) : 16'($signed(10'($urandom)));
      for (int r = 0; r < 4; r++) exp_res[r] = ref_row(r);
      run_pass(0, 0, 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
